fp32_div_seq: RTL

Iterative IEEE-754 single-precision divider (res = opr1 / opr2) for the FFT datapath. It is the inverse operation of the combinational fp32 multiplier and uses the same operand classification, truncation (no rounding) and special-value encodings.
It uses a restoring mantissa divider, one quotient bit per cycle, controlled by a start/done handshake.

---
 rtl/fp32_pkg.sv | 9 +
 rtl/fp32_div_seq_if.sv | 11 +
 rtl/fp32_classify.sv | 14 +
 rtl/fp32_div_seq.sv | 83 ++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared single-precision field widths, status codes and divider FSM states
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [FRAC_W-1:0] NAN_FRAC = 23'h00000F;
  typedef enum logic [1:0] {USUAL = 2'b00, ZERO = 2'b01, INF = 2'b10, NAN = 2'b11} status_t;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;
endpackage

// File: rtl/fp32_div_seq_if.sv
// fp32_div_seq_if: start/done request bus of the iterative divider
interface fp32_div_seq_if;
  logic start;
  logic [31:0] opr1;
  logic [31:0] opr2;
  logic busy;
  logic done;
  logic [31:0] res;
  modport master(output start, opr1, opr2, input busy, done, res);
  modport slave(input start, opr1, opr2, output busy, done, res);
endinterface

// File: rtl/fp32_classify.sv
// fp32_classify: maps exponent/fraction fields to USUAL/ZERO/INF/NAN
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [30:0] op_i,
  output status_t     st_o
);
  logic [EXP_W-1:0] e;
  logic [FRAC_W-1:0] f;
  assign e = op_i[30:23];
  assign f = op_i[22:0];
  // exp=0 with a nonzero fraction is treated as a normal number
  always_comb st_o = &e ? (|f ? NAN : INF) : ((~|e && ~|f) ? ZERO : USUAL);
endmodule

// File: rtl/fp32_div_seq.sv
// fp32_div_seq: restoring fp32 divider, one quotient bit per cycle, truncating
module fp32_div_seq
  import fp32_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fp32_div_seq_if.slave bus
);
  state_t state_q, state_d;
  logic s_q, s_d, busy_q, busy_d, done_q, done_d;
  logic [EXP_W-1:0] e1_q, e1_d, e2_q, e2_d;
  logic [23:0] n2_q, n2_d;
  logic [24:0] rem_q, rem_d, q_q, q_d, dif;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] res_q, res_d, sres;
  status_t c1, c2;
  logic s_in, nan_c, inf_c, ge;
  logic signed [10:0] e;
  logic [FRAC_W-1:0] frac;
  fp32_classify u_c1 (.op_i(bus.opr1[30:0]), .st_o(c1));
  fp32_classify u_c2 (.op_i(bus.opr2[30:0]), .st_o(c2));
  assign s_in = bus.opr1[31] ^ bus.opr2[31];
  assign nan_c = c1 == NAN || c2 == NAN || (c1 == INF && c2 == INF) || (c1 == ZERO && c2 == ZERO);
  assign inf_c = c1 == INF || c2 == ZERO;
  assign sres = nan_c ? {s_in, 8'hFF, NAN_FRAC} : (inf_c ? {s_in, 8'hFF, 23'h0} : {s_in, 31'h0});
  assign ge = rem_q >= {1'b0, n2_q};
  assign dif = rem_q - {1'b0, n2_q};
  // quotient >= 1 sits one bit higher and needs one less exponent correction
  assign e = $signed({3'b0, e1_q}) - $signed({3'b0, e2_q}) + (q_q[24] ? 11'(BIAS) : 11'(BIAS - 1));
  assign frac = q_q[24] ? q_q[23:1] : q_q[22:0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res = res_q;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      {s_q, busy_q, done_q, e1_q, e2_q, n2_q, rem_q, q_q, cnt_q, res_q} <= '0;
    end else begin
      state_q <= state_d;
      {s_q, busy_q, done_q, e1_q, e2_q, n2_q, rem_q, q_q, cnt_q, res_q} <=
        {s_d, busy_d, done_d, e1_d, e2_d, n2_d, rem_d, q_d, cnt_d, res_d};
    end
  end
  // next state: accept, shift-subtract iterations, normalise and pack
  always_comb begin
    state_d = state_q;
    {s_d, busy_d, e1_d, e2_d, n2_d, rem_d, q_d, cnt_d, res_d} =
      {s_q, busy_q, e1_q, e2_q, n2_q, rem_q, q_q, cnt_q, res_q};
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        s_d = s_in;
        e1_d = bus.opr1[30:23];
        e2_d = bus.opr2[30:23];
        n2_d = {1'b1, bus.opr2[22:0]};
        if (c1 != USUAL || c2 != USUAL) begin
          res_d = sres;
          done_d = 1'b1;
        end else begin
          rem_d = {2'b01, bus.opr1[22:0]};
          q_d = '0;
          cnt_d = 5'd24;
          busy_d = 1'b1;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        q_d = {q_q[23:0], ge};
        rem_d = {(ge ? dif[23:0] : rem_q[23:0]), 1'b0};
        cnt_d = cnt_q - 5'd1;
        state_d = cnt_q == 5'd0 ? S_NORM : S_DIV;
      end
      S_NORM: begin
        res_d = e > 11'sd254 ? {s_q, 8'hFF, 23'h0} : (e <= 11'sd0 ? {s_q, 31'h0} : {s_q, e[7:0], frac});
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
